traffic_light_ctrl: RTL and testbench

TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

---
 rtl/traffic_pkg.sv | 12 +
 rtl/tl_phase_counter.sv | 28 ++
 rtl/traffic_light_ctrl.sv | 108 ++++++++++
 tb/tb_traffic_light_ctrl.sv | 138 +++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared state encoding and counter width for the traffic light controller
package traffic_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        RED    = 2'b00,
        GREEN  = 2'b01,
        YELLOW = 2'b10
    } tl_state_e;

endpackage

// File: rtl/tl_phase_counter.sv
// rtl/tl_phase_counter.sv - phase counter with synchronous clear and enable, wraps modulo 2**CNT_W
module tl_phase_counter
    import traffic_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_en) begin
            if (i_clr) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/traffic_light_ctrl.sv
// rtl/traffic_light_ctrl.sv - RED/GREEN/YELLOW sequencer with pedestrian latch and walk lamp
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ped_req,
    input  logic             eq_red_time,
    input  logic             eq_yellow_time,
    input  logic             eq_green_time,
    output logic [CNT_W-1:0] count,
    output logic             red,
    output logic             yellow,
    output logic             green,
    output logic             walk,
    output logic             ped_pending
);

    tl_state_e        r_state;
    tl_state_e        w_next_state;
    logic             w_phase_done;
    logic             w_adv;
    logic             w_serve;
    logic [CNT_W-1:0] w_count;
    logic             r_red;
    logic             r_yellow;
    logic             r_green;
    logic             r_walk;
    logic             r_ped_pending;

    // Only the comparator flag of the current phase is looked at.
    always_comb begin
        w_phase_done = 1'b0;
        w_next_state = r_state;
        case (r_state)
            RED: begin
                if (eq_red_time) begin
                    w_phase_done = 1'b1;
                    w_next_state = GREEN;
                end
            end
            GREEN: begin
                if (eq_green_time ||
                    (r_ped_pending && (w_count >= CNT_W'(MIN_GREEN)))) begin
                    w_phase_done = 1'b1;
                    w_next_state = YELLOW;
                end
            end
            YELLOW: begin
                if (eq_yellow_time) begin
                    w_phase_done = 1'b1;
                    w_next_state = RED;
                end
            end
            default: begin
                w_phase_done = 1'b1;
                w_next_state = RED;
            end
        endcase
    end

    assign w_adv   = en & w_phase_done;
    assign w_serve = w_adv & (r_state == YELLOW) & r_ped_pending;

    tl_phase_counter u_counter (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_adv),
        .i_en    (en),
        .o_count (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= RED;
            r_red         <= 1'b1;
            r_yellow      <= 1'b0;
            r_green       <= 1'b0;
            r_walk        <= 1'b0;
            r_ped_pending <= 1'b0;
        end else begin
            if (en) begin
                r_state  <= w_next_state;
                r_red    <= (w_next_state == RED);
                r_yellow <= (w_next_state == YELLOW);
                r_green  <= (w_next_state == GREEN);
            end
            if (w_serve) begin
                r_walk <= 1'b1;
            end else if (w_adv && (r_state == RED)) begin
                r_walk <= 1'b0;
            end
            // A new request on the serving edge keeps the latch set.
            r_ped_pending <= ped_req | (r_ped_pending & ~w_serve);
        end
    end

    assign count       = w_count;
    assign red         = r_red;
    assign yellow      = r_yellow;
    assign green       = r_green;
    assign walk        = r_walk;
    assign ped_pending = r_ped_pending;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb/tb_traffic_light_ctrl.sv - directed self-checking bench for traffic_light_ctrl
module tb_traffic_light_ctrl;

    localparam logic [1:0] S_R = 2'd0;
    localparam logic [1:0] S_G = 2'd1;
    localparam logic [1:0] S_Y = 2'd2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       ped_req = 1'b0;
    logic [3:0] red_time = 4'd3;
    logic [3:0] green_time = 4'd5;
    logic [3:0] yellow_time = 4'd1;
    logic       eq_red_time;
    logic       eq_yellow_time;
    logic       eq_green_time;
    logic [3:0] count;
    logic       red;
    logic       yellow;
    logic       green;
    logic       walk;
    logic       ped_pending;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign eq_red_time    = (count == red_time);
    assign eq_yellow_time = (count == yellow_time);
    assign eq_green_time  = (count == green_time);

    traffic_light_ctrl #(.MIN_GREEN(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .ped_req        (ped_req),
        .eq_red_time    (eq_red_time),
        .eq_yellow_time (eq_yellow_time),
        .eq_green_time  (eq_green_time),
        .count          (count),
        .red            (red),
        .yellow         (yellow),
        .green          (green),
        .walk           (walk),
        .ped_pending    (ped_pending)
    );

    task automatic step_chk(input string tag, input logic [1:0] st, input int cnt,
                            input logic w, input logic p);
        logic [8:0] obs;
        logic [8:0] exp;
        @(posedge clk);
        #1;
        exp = {st == S_R, st == S_Y, st == S_G, w, p, 4'(cnt)};
        obs = {red, yellow, green, walk, ped_pending, count};
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed r/y/g/walk/pend/count=%b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset overrides requests and comparator inputs.
        rst = 1'b1;
        ped_req = 1'b1;
        step_chk("reset", S_R, 0, 0, 0);
        ped_req = 1'b0;
        rst = 1'b0;

        // Free run: red 4, green 6, yellow 2, then red again.
        for (int i = 1; i <= 3; i++) step_chk("free_red1", S_R, i, 0, 0);
        for (int i = 0; i <= 5; i++) step_chk("free_green", S_G, i, 0, 0);
        for (int i = 0; i <= 1; i++) step_chk("free_yellow", S_Y, i, 0, 0);
        for (int i = 0; i <= 3; i++) step_chk("free_red2", S_R, i, 0, 0);
        step_chk("free_green2", S_G, 0, 0, 0);

        // Pedestrian request at GREEN count 0 shortens green to 3 cycles.
        ped_req = 1'b1;
        step_chk("ped_g1", S_G, 1, 0, 1);
        ped_req = 1'b0;
        step_chk("ped_g2", S_G, 2, 0, 1);
        step_chk("ped_y0", S_Y, 0, 0, 1);
        step_chk("ped_y1", S_Y, 1, 0, 1);
        for (int i = 0; i <= 3; i++) step_chk("ped_walk_red", S_R, i, 1, 0);
        step_chk("ped_walk_clear", S_G, 0, 0, 0);

        // Enable low freezes GREEN at count 3.
        for (int i = 1; i <= 3; i++) step_chk("pre_hold", S_G, i, 0, 0);
        en = 1'b0;
        for (int i = 0; i < 3; i++) step_chk("hold", S_G, 3, 0, 0);
        en = 1'b1;
        step_chk("resume", S_G, 4, 0, 0);
        step_chk("resume5", S_G, 5, 0, 0);
        step_chk("pre_rst_y0", S_Y, 0, 0, 0);
        step_chk("pre_rst_y1", S_Y, 1, 0, 0);

        // Mid-phase reset at YELLOW count 1.
        rst = 1'b1;
        step_chk("midrst", S_R, 0, 0, 0);
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) step_chk("post_rst_red", S_R, i, 0, 0);
        step_chk("post_rst_green", S_G, 0, 0, 0);

        // Request again on the serving YELLOW->RED edge: set wins.
        ped_req = 1'b1;
        step_chk("dbl_g1", S_G, 1, 0, 1);
        ped_req = 1'b0;
        step_chk("dbl_g2", S_G, 2, 0, 1);
        step_chk("dbl_y0", S_Y, 0, 0, 1);
        step_chk("dbl_y1", S_Y, 1, 0, 1);
        ped_req = 1'b1;
        step_chk("dbl_red0", S_R, 0, 1, 1);
        ped_req = 1'b0;
        for (int i = 1; i <= 3; i++) step_chk("dbl_red", S_R, i, 1, 1);
        step_chk("dbl_g0b", S_G, 0, 0, 1);
        step_chk("dbl_g1b", S_G, 1, 0, 1);
        step_chk("dbl_g2b", S_G, 2, 0, 1);
        step_chk("dbl_y0b", S_Y, 0, 0, 1);
        step_chk("dbl_y1b", S_Y, 1, 0, 1);
        step_chk("dbl_served", S_R, 0, 1, 0);

        // Boundary times: green 15, red/yellow 0.
        green_time = 4'd15;
        red_time = 4'd0;
        yellow_time = 4'd0;
        for (int i = 0; i <= 15; i++) step_chk("long_green", S_G, i, 0, 0);
        step_chk("short_yellow", S_Y, 0, 0, 0);
        step_chk("short_red", S_R, 0, 0, 0);
        step_chk("short_red_exit", S_G, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
